ysyx_24100006_wb_stage: RTL and testbench

Parametrised, registered write-back stage that sits between the MEM stage and the GPR/CSR register files. It captures one instruction per valid/ready handshake into a holding register and selects the GPR and CSR write data. It commits the writes one cycle later and retires the instruction, with a downstream stall and an instret counter. It is the pipelined successor of the two-state single-issue write-back: it allows back-to-back throughput, x0 suppression, CSR clear-mode and configurable widths.

---
 rtl/ysyx_24100006_wb_pkg.sv | 31 +++
 rtl/ysyx_24100006_wb_datasel.sv | 43 ++++
 rtl/ysyx_24100006_wb_stage.sv | 140 ++++++++++++++
 tb/tb_ysyx_24100006_wb_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_wb_pkg.sv
// Shared types and select codes for the write-back stage.
package ysyx_24100006_wb_pkg;

    localparam logic [2:0] GPR_SEL_IMM = 3'd0;
    localparam logic [2:0] GPR_SEL_ALU = 3'd1;
    localparam logic [2:0] GPR_SEL_PC4 = 3'd2;
    localparam logic [2:0] GPR_SEL_MEM = 3'd3;
    localparam logic [2:0] GPR_SEL_CSR = 3'd4;

    localparam logic [1:0] CSR_SEL_PC  = 2'd0;
    localparam logic [1:0] CSR_SEL_RS1 = 2'd1;
    localparam logic [1:0] CSR_SEL_SET = 2'd2;
    localparam logic [1:0] CSR_SEL_CLR = 2'd3;

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_e;

    // Width-independent control fields of the held instruction; the
    // XLEN-wide operands live beside it in the top so widths stay parametric.
    typedef struct packed {
        logic       gpr_we;
        logic       csr_we;
        logic [2:0] gpr_sel;
        logic [1:0] csr_sel;
        logic       irq;
        logic [7:0] irq_no;
    } wb_entry_t;

endpackage

// File: rtl/ysyx_24100006_wb_datasel.sv
// Combinational GPR/CSR write-data selection for the held instruction.
module ysyx_24100006_wb_datasel
    import ysyx_24100006_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      gpr_sel,
    input  logic [1:0]      csr_sel,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu,
    input  logic [XLEN-1:0] mem,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] gpr_wdata,
    output logic [XLEN-1:0] csr_wdata
);

    // Unused select codes 5..7 yield zero; pc+4 wraps at 2^XLEN.
    always_comb begin
        gpr_wdata = '0;
        case (gpr_sel)
            GPR_SEL_IMM: gpr_wdata = imm;
            GPR_SEL_ALU: gpr_wdata = alu;
            GPR_SEL_PC4: gpr_wdata = pc + XLEN'(4);
            GPR_SEL_MEM: gpr_wdata = mem;
            GPR_SEL_CSR: gpr_wdata = csr_rdata;
            default:     gpr_wdata = '0;
        endcase
    end

    always_comb begin
        csr_wdata = '0;
        case (csr_sel)
            CSR_SEL_PC:  csr_wdata = pc;
            CSR_SEL_RS1: csr_wdata = rs1;
            CSR_SEL_SET: csr_wdata = csr_rdata | rs1;
            CSR_SEL_CLR: csr_wdata = csr_rdata & ~rs1;
            default:     csr_wdata = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24100006_wb_stage.sv
// Registered write-back stage: one-entry holding register, commit to GPR/CSR
// files one cycle after capture, downstream stall and retire counter.
module ysyx_24100006_wb_stage
    import ysyx_24100006_wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RF_AW  = 4,
    parameter int CSR_AW = 12,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_mem,
    input  logic [XLEN-1:0]   in_csr_rdata,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [RF_AW-1:0]  in_rd,
    input  logic [CSR_AW-1:0] in_csr_addr,
    input  logic              in_gpr_we,
    input  logic              in_csr_we,
    input  logic [2:0]        in_gpr_sel,
    input  logic [1:0]        in_csr_sel,
    input  logic              in_irq,
    input  logic [7:0]        in_irq_no,
    input  logic              wb_stall,
    output logic              gpr_we,
    output logic [RF_AW-1:0]  gpr_waddr,
    output logic [XLEN-1:0]   gpr_wdata,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              irq_out,
    output logic [7:0]        irq_no_out,
    output logic              retire,
    output logic [XLEN-1:0]   retire_pc,
    output logic              hz_valid,
    output logic [RF_AW-1:0]  hz_rd,
    output logic [CNT_W-1:0]  instret
);

    // Handshake: an instruction transfers on a rising edge where
    // in_valid & in_ready; in_ready never looks at in_valid.
    wb_state_e         state;
    wb_entry_t         ent;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   alu_q;
    logic [XLEN-1:0]   mem_q;
    logic [XLEN-1:0]   crd_q;
    logic [XLEN-1:0]   rs1_q;
    logic [RF_AW-1:0]  rd_q;
    logic [CSR_AW-1:0] csr_addr_q;

    logic              full;
    logic              commit;
    logic              capture;
    logic              rd_nz;
    logic [XLEN-1:0]   sel_gpr_data;
    logic [XLEN-1:0]   sel_csr_data;

    assign full     = (state == WB_FULL);
    assign commit   = full & ~wb_stall;
    assign in_ready = ~full | commit;
    assign capture  = in_valid & in_ready;
    assign rd_nz    = (rd_q != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WB_EMPTY;
            ent        <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            alu_q      <= '0;
            mem_q      <= '0;
            crd_q      <= '0;
            rs1_q      <= '0;
            rd_q       <= '0;
            csr_addr_q <= '0;
            instret    <= '0;
        end else begin
            if (capture) begin
                state          <= WB_FULL;
                ent.gpr_we     <= in_gpr_we;
                ent.csr_we     <= in_csr_we;
                ent.gpr_sel    <= in_gpr_sel;
                ent.csr_sel    <= in_csr_sel;
                ent.irq        <= in_irq;
                ent.irq_no     <= in_irq_no;
                pc_q           <= in_pc;
                imm_q          <= in_imm;
                alu_q          <= in_alu;
                mem_q          <= in_mem;
                crd_q          <= in_csr_rdata;
                rs1_q          <= in_rs1;
                rd_q           <= in_rd;
                csr_addr_q     <= in_csr_addr;
            end else if (commit) begin
                state <= WB_EMPTY;
            end
            if (commit) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    ysyx_24100006_wb_datasel #(
        .XLEN (XLEN)
    ) u_datasel (
        .gpr_sel   (ent.gpr_sel),
        .csr_sel   (ent.csr_sel),
        .pc        (pc_q),
        .imm       (imm_q),
        .alu       (alu_q),
        .mem       (mem_q),
        .csr_rdata (crd_q),
        .rs1       (rs1_q),
        .gpr_wdata (sel_gpr_data),
        .csr_wdata (sel_csr_data)
    );

    // Writes to x0 are dropped but the instruction still retires.
    assign gpr_we     = commit & ent.gpr_we & rd_nz;
    assign csr_we     = commit & ent.csr_we;
    assign irq_out    = commit & ent.irq;
    assign retire     = commit;
    assign hz_valid   = full & ent.gpr_we & rd_nz;

    assign gpr_waddr  = full ? rd_q         : '0;
    assign gpr_wdata  = full ? sel_gpr_data : '0;
    assign csr_waddr  = full ? csr_addr_q   : '0;
    assign csr_wdata  = full ? sel_csr_data : '0;
    assign irq_no_out = full ? ent.irq_no   : '0;
    assign retire_pc  = full ? pc_q         : '0;
    assign hz_rd      = full ? rd_q         : '0;

endmodule

// File: tb/tb_ysyx_24100006_wb_stage.sv
// Directed scoreboard bench for the write-back stage.
module tb_ysyx_24100006_wb_stage;

    localparam int XLEN   = 32;
    localparam int RF_AW  = 4;
    localparam int CSR_AW = 12;
    localparam int EW     = 1 + RF_AW + XLEN + 1 + CSR_AW + XLEN + 1 + 8 + XLEN;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc, in_imm, in_alu, in_mem, in_csr_rdata, in_rs1;
    logic [RF_AW-1:0]  in_rd;
    logic [CSR_AW-1:0] in_csr_addr;
    logic              in_gpr_we, in_csr_we;
    logic [2:0]        in_gpr_sel;
    logic [1:0]        in_csr_sel;
    logic              in_irq;
    logic [7:0]        in_irq_no;
    logic              wb_stall;
    logic              gpr_we, csr_we, irq_out, retire, hz_valid;
    logic [RF_AW-1:0]  gpr_waddr, hz_rd;
    logic [XLEN-1:0]   gpr_wdata, csr_wdata, retire_pc;
    logic [CSR_AW-1:0] csr_waddr;
    logic [7:0]        irq_no_out;
    logic [63:0]       instret;

    logic              d4_in_ready, d4_gpr_we, d4_csr_we, d4_irq_out, d4_retire, d4_hz_valid;
    logic [RF_AW-1:0]  d4_gpr_waddr, d4_hz_rd;
    logic [XLEN-1:0]   d4_gpr_wdata, d4_csr_wdata, d4_retire_pc;
    logic [CSR_AW-1:0] d4_csr_waddr;
    logic [7:0]        d4_irq_no_out;
    logic [3:0]        d4_instret;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] m_act, m_exp;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_24100006_wb_stage #(.XLEN(XLEN), .RF_AW(RF_AW), .CSR_AW(CSR_AW), .CNT_W(64)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_alu(in_alu), .in_mem(in_mem),
        .in_csr_rdata(in_csr_rdata), .in_rs1(in_rs1), .in_rd(in_rd), .in_csr_addr(in_csr_addr),
        .in_gpr_we(in_gpr_we), .in_csr_we(in_csr_we), .in_gpr_sel(in_gpr_sel), .in_csr_sel(in_csr_sel),
        .in_irq(in_irq), .in_irq_no(in_irq_no), .wb_stall(wb_stall),
        .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .irq_out(irq_out), .irq_no_out(irq_no_out), .retire(retire), .retire_pc(retire_pc),
        .hz_valid(hz_valid), .hz_rd(hz_rd), .instret(instret)
    );

    ysyx_24100006_wb_stage #(.XLEN(XLEN), .RF_AW(RF_AW), .CSR_AW(CSR_AW), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d4_in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_alu(in_alu), .in_mem(in_mem),
        .in_csr_rdata(in_csr_rdata), .in_rs1(in_rs1), .in_rd(in_rd), .in_csr_addr(in_csr_addr),
        .in_gpr_we(in_gpr_we), .in_csr_we(in_csr_we), .in_gpr_sel(in_gpr_sel), .in_csr_sel(in_csr_sel),
        .in_irq(in_irq), .in_irq_no(in_irq_no), .wb_stall(wb_stall),
        .gpr_we(d4_gpr_we), .gpr_waddr(d4_gpr_waddr), .gpr_wdata(d4_gpr_wdata),
        .csr_we(d4_csr_we), .csr_waddr(d4_csr_waddr), .csr_wdata(d4_csr_wdata),
        .irq_out(d4_irq_out), .irq_no_out(d4_irq_no_out), .retire(d4_retire), .retire_pc(d4_retire_pc),
        .hz_valid(d4_hz_valid), .hz_rd(d4_hz_rd), .instret(d4_instret)
    );

    function automatic logic [EW-1:0] pack_exp(
        input logic gwe, input logic [RF_AW-1:0] ga, input logic [XLEN-1:0] gd,
        input logic cwe, input logic [CSR_AW-1:0] ca, input logic [XLEN-1:0] cd,
        input logic irq, input logic [7:0] ino, input logic [XLEN-1:0] pc);
        return {gwe, ga, gd, cwe, ca, cd, irq, ino, pc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every retire pops one expected commit; idle cycles must not write.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (retire) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_retire: pc 0x%0h with nothing expected", retire_pc);
                end else begin
                    m_exp = exp_q.pop_front();
                    m_act = pack_exp(gpr_we, gpr_waddr, gpr_wdata, csr_we, csr_waddr, csr_wdata,
                                     irq_out, irq_no_out, retire_pc);
                    if (m_act !== m_exp) begin
                        n_fail++;
                        $display("FAIL commit_fields: got 0x%0h expected 0x%0h", m_act, m_exp);
                    end
                end
            end else begin
                n_chk++;
                if (gpr_we | csr_we | irq_out) begin
                    n_fail++;
                    $display("FAIL idle_we: got gpr_we=%0b csr_we=%0b irq=%0b expected 0", gpr_we, csr_we, irq_out);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic send(
        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm, input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] mem, input logic [XLEN-1:0] crd, input logic [XLEN-1:0] rs1,
        input logic [RF_AW-1:0] rd, input logic [CSR_AW-1:0] ca, input logic gwe, input logic cwe,
        input logic [2:0] gsel, input logic [1:0] csel, input logic irq, input logic [7:0] ino,
        input logic [EW-1:0] exp, output int waits);
        in_pc = pc; in_imm = imm; in_alu = alu; in_mem = mem; in_csr_rdata = crd; in_rs1 = rs1;
        in_rd = rd; in_csr_addr = ca; in_gpr_we = gwe; in_csr_we = cwe;
        in_gpr_sel = gsel; in_csr_sel = csel; in_irq = irq; in_irq_no = ino;
        in_valid = 1'b1;
        waits = 0;
        #1;
        while (!in_ready && waits < 50) begin
            next_cycle();
            #1;
            waits++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, waits);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(exp);
            next_cycle();
        end
    endtask

    localparam logic [XLEN-1:0] B2B_GD [8] = '{32'h100, 32'h201, 32'h100C, 32'h303, 32'h404, 32'h0, 32'h0, 32'h0};
    localparam logic [XLEN-1:0] B2B_CD [8] = '{32'h1000, 32'hFF, 32'h4FF, 32'h400, 32'h1010, 32'hFF, 32'h4FF, 32'h400};

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int w, wb;
        logic [XLEN-1:0] pc;
        reset = 1'b1; in_valid = 1'b0; wb_stall = 1'b0;
        in_pc = '0; in_imm = '0; in_alu = '0; in_mem = '0; in_csr_rdata = '0; in_rs1 = '0;
        in_rd = '0; in_csr_addr = '0; in_gpr_we = 1'b0; in_csr_we = 1'b0;
        in_gpr_sel = '0; in_csr_sel = '0; in_irq = 1'b0; in_irq_no = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_retire", 64'(retire), 64'd0);
        check("reset_gpr_we", 64'(gpr_we), 64'd0);
        check("reset_hz_valid", 64'(hz_valid), 64'd0);
        check("reset_instret", instret, 64'd0);
        check("reset_gpr_waddr", 64'(gpr_waddr), 64'd0);
        next_cycle();

        // Single ALU op.
        send(32'h8000_0000, 32'h0, 32'h1234, 32'h0, 32'h0, 32'h0, 4'd5, 12'h0, 1'b1, 1'b0, 3'd1, 2'd0, 1'b0, 8'h0,
             pack_exp(1'b1, 4'd5, 32'h1234, 1'b0, 12'h0, 32'h8000_0000, 1'b0, 8'h0, 32'h8000_0000), w);
        idle();
        @(negedge clk);
        check("alu_hz_valid", 64'(hz_valid), 64'd1);
        check("alu_hz_rd", 64'(hz_rd), 64'd5);
        check("alu_instret_before", instret, 64'd0);
        next_cycle();
        @(negedge clk);
        check("alu_instret", instret, 64'd1);
        check("alu_empty_hz", 64'(hz_valid), 64'd0);
        next_cycle();

        // Write to x0 is suppressed but retires.
        send(32'h8000_0004, 32'h0, 32'h55, 32'h0, 32'h0, 32'h77, 4'd0, 12'h0, 1'b1, 1'b0, 3'd1, 2'd1, 1'b0, 8'h0,
             pack_exp(1'b0, 4'd0, 32'h55, 1'b0, 12'h0, 32'h77, 1'b0, 8'h0, 32'h8000_0004), w);
        idle();
        @(negedge clk);
        check("x0_hz_valid", 64'(hz_valid), 64'd0);
        check("x0_retire", 64'(retire), 64'd1);
        next_cycle();

        // Eight back-to-back instructions across every select code.
        for (int i = 0; i < 8; i++) begin
            pc = 32'h1000 + 32'(4 * i);
            send(pc, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i), 32'h400 + 32'(i), 32'hFF,
                 RF_AW'(i + 1), 12'h300 + 12'(i), 1'b1, 1'(i % 2), 3'(i), 2'(i % 4), 1'(i == 6), 8'(i * 3),
                 pack_exp(1'b1, RF_AW'(i + 1), B2B_GD[i], 1'(i % 2), 12'h300 + 12'(i), B2B_CD[i],
                          1'(i == 6), 8'(i * 3), pc), w);
            check("b2b_in_ready_waits", 64'(w), 64'd0);
        end
        idle();
        next_cycle();
        @(negedge clk);
        check("b2b_instret", instret, 64'd10);
        next_cycle();

        // Stall for three cycles while a second instruction waits.
        wb_stall = 1'b1;
        send(32'h2000, 32'h0, 32'hABCD, 32'h0, 32'h0, 32'h1111, 4'd9, 12'h305, 1'b1, 1'b1, 3'd1, 2'd1, 1'b0, 8'h0,
             pack_exp(1'b1, 4'd9, 32'hABCD, 1'b1, 12'h305, 32'h1111, 1'b0, 8'h0, 32'h2000), w);
        fork
            send(32'h2004, 32'h0, 32'h42, 32'h0, 32'h0, 32'h0, 4'd10, 12'h0, 1'b1, 1'b0, 3'd1, 2'd0, 1'b0, 8'h0,
                 pack_exp(1'b1, 4'd10, 32'h42, 1'b0, 12'h0, 32'h2004, 1'b0, 8'h0, 32'h2004), wb);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_gpr_we", 64'(gpr_we), 64'd0);
                    check("stall_csr_we", 64'(csr_we), 64'd0);
                    check("stall_hz_valid", 64'(hz_valid), 64'd1);
                    check("stall_frozen_waddr", 64'(gpr_waddr), 64'd9);
                    check("stall_frozen_wdata", 64'(gpr_wdata), 64'hABCD);
                end
                @(posedge clk);
                #1 wb_stall = 1'b0;
            end
        join
        check("stall_wait_cycles", 64'(wb), 64'd3);
        idle();
        next_cycle();
        @(negedge clk);
        check("stall_instret", instret, 64'd12);
        next_cycle();

        // CSR set/clear modes and pc+4 wrap.
        send(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'hF0F0, 32'h00FF, 4'd1, 12'h300, 1'b1, 1'b1, 3'd2, 2'd2, 1'b0, 8'h0,
             pack_exp(1'b1, 4'd1, 32'h0, 1'b1, 12'h300, 32'hF0FF, 1'b0, 8'h0, 32'hFFFF_FFFC), w);
        send(32'h100, 32'h0, 32'h0, 32'h0, 32'hF0F0, 32'h00FF, 4'd2, 12'h300, 1'b1, 1'b1, 3'd4, 2'd3, 1'b1, 8'h0B,
             pack_exp(1'b1, 4'd2, 32'hF0F0, 1'b1, 12'h300, 32'hF000, 1'b1, 8'h0B, 32'h100), w);
        idle();
        next_cycle();
        @(negedge clk);
        check("csr_instret", instret, 64'd14);
        next_cycle();

        // Asynchronous reset while a commit is presented.
        send(32'h3000, 32'h0, 32'h99, 32'h0, 32'h0, 32'h0, 4'd7, 12'h0, 1'b1, 1'b0, 3'd1, 2'd0, 1'b0, 8'h0,
             pack_exp(1'b1, 4'd7, 32'h99, 1'b0, 12'h0, 32'h3000, 1'b0, 8'h0, 32'h3000), w);
        idle();
        #1;
        check("prereset_gpr_we", 64'(gpr_we), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("async_retire", 64'(retire), 64'd0);
        check("async_gpr_we", 64'(gpr_we), 64'd0);
        check("async_hz_valid", 64'(hz_valid), 64'd0);
        check("async_instret", instret, 64'd0);
        exp_q.delete();
        next_cycle();
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("postreset_retire", 64'(retire), 64'd0);
        end
        next_cycle();

        // Seventeen commits: 64-bit counter reads 17, 4-bit counter wraps to 1.
        for (int i = 0; i < 17; i++) begin
            send(32'h4000, 32'h0, 32'(i), 32'h0, 32'h0, 32'h0, RF_AW'(i % 15 + 1), 12'h0, 1'b1, 1'b0,
                 3'd1, 2'd0, 1'b0, 8'h0,
                 pack_exp(1'b1, RF_AW'(i % 15 + 1), 32'(i), 1'b0, 12'h0, 32'h4000, 1'b0, 8'h0, 32'h4000), w);
        end
        idle();
        next_cycle();
        @(negedge clk);
        check("wrap_instret64", instret, 64'd17);
        check("wrap_instret4", 64'(d4_instret), 64'd1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
